// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier family.
//   state_e        : controller states (IDLE, CALC, DONE)
//   booth_op_e     : radix-2 Booth recoding of {Qreg[0], q_1}
//   cnt_width()    : step-counter width for a given operand width
//   booth_decode() : maps the recoding bit pair to an operation
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // Counter must reach WIDTH+1 steps.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

    function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
        booth_op_e op;
        case ({q0, q_1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of the
// multiplicand into the accumulator, then an arithmetic right shift of the
// concatenation {A, Qreg, q_1}.
//   a_i, q_i, q1_i : current accumulator, multiplier register, trailing bit
//   m_i            : multiplicand (already extended to W1 bits)
//   a_o, q_o, q1_o : values after the step
module booth_step
    import booth_pkg::*;
#(
    parameter int W1 = 9
) (
    input  logic [W1-1:0] a_i,
    input  logic [W1-1:0] q_i,
    input  logic          q1_i,
    input  logic [W1-1:0] m_i,
    output logic [W1-1:0] a_o,
    output logic [W1-1:0] q_o,
    output logic          q1_o
);

    logic [W1-1:0] sum;

    always_comb begin
        sum = a_i;
        case (booth_decode(q_i[0], q1_i))
            BOOTH_ADD: sum = a_i + m_i;
            BOOTH_SUB: sum = a_i - m_i;
            default:   sum = a_i;
        endcase
        // Arithmetic shift: replicate A's sign, A's LSB moves into Qreg.
        a_o  = {sum[W1-1], sum[W1-1:1]};
        q_o  = {sum[0], q_i[W1-1:1]};
        q1_o = q_i[0];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier, one step per clock, WIDTH+1 steps.
// Operands are extended by one bit (sign or zero per signed_mode) so the
// most-negative signed value and full-range unsigned values are exact.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid / in_ready    : operand handshake (ready only in IDLE)
//   multiplicand, multiplier, signed_mode : operation inputs
//   out_valid / out_ready  : product handshake (valid held until taken)
//   product                : 2*WIDTH-bit result
//   busy                   : high in CALC or DONE
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int W1 = WIDTH + 1;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(W1 - 1);

    state_e             state_q, state_d;
    logic [W1-1:0]      a_q, a_d;
    logic [W1-1:0]      qr_q, qr_d;
    logic               q1_q, q1_d;
    logic [W1-1:0]      m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [W1-1:0]      step_a;
    logic [W1-1:0]      step_q;
    logic               step_q1;

    function automatic logic [W1-1:0] extend(input logic [WIDTH-1:0] x, input logic sgn);
        return sgn ? {x[WIDTH-1], x} : {1'b0, x};
    endfunction

    booth_step #(
        .W1(W1)
    ) u_step (
        .a_i  (a_q),
        .q_i  (qr_q),
        .q1_i (q1_q),
        .m_i  (m_q),
        .a_o  (step_a),
        .q_o  (step_q),
        .q1_o (step_q1)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        qr_d    = qr_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        case (state_q)
            IDLE: begin
                // The mode is consumed by the extension here, so the
                // operation is frozen to it without a separate mode flop.
                if (in_valid) begin
                    a_d     = '0;
                    qr_d    = extend(multiplier, signed_mode);
                    q1_d    = 1'b0;
                    m_d     = extend(multiplicand, signed_mode);
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d   = step_a;
                qr_d  = step_q;
                q1_d  = step_q1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    // Low 2*WIDTH bits of the 2*W1-bit {A, Qreg}.
                    prod_d  = {step_a[W1-3:0], step_q};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic        iv8, ir8, sm8, ov8, or8, busy8;
    logic [7:0]  m8, q8;
    logic [15:0] p8;
    // WIDTH=4 instance
    logic        iv4, ir4, sm4, ov4, or4, busy4;
    logic [3:0]  m4, q4;
    logic [7:0]  p4;

    booth_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .multiplicand(m8), .multiplier(q8), .signed_mode(sm8),
        .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
    );

    booth_mult_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .multiplicand(m4), .multiplier(q4), .signed_mode(sm4),
        .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] sb8[$];
    logic [7:0]  sb4[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: interpret operands of width w as signed/unsigned, multiply wide.
    function automatic logic [15:0] ref_mul(input logic [7:0] m, input logic [7:0] q,
                                            input logic sm, input int w);
        longint a, b, p, mask;
        mask = (longint'(1) << w) - 1;
        a = longint'(m) & mask;
        b = longint'(q) & mask;
        if (sm && a[w-1]) a = a - (longint'(1) << w);
        if (sm && b[w-1]) b = b - (longint'(1) << w);
        p = (a * b) & ((longint'(1) << (2 * w)) - 1);
        return 16'(p);
    endfunction

    task automatic op8(input logic [7:0] m, input logic [7:0] q, input logic sm,
                       input logic [15:0] exp, input int hold);
        int lat;
        logic [15:0] held;
        logic [15:0] e;
        @(negedge clk);
        check("accept_ready8", 64'(ir8), 64'd1);
        m8 = m; q8 = q; sm8 = sm; iv8 = 1'b1;
        @(posedge clk);
        sb8.push_back(exp);
        #1;
        iv8 = 1'b0; m8 = ~m; q8 = ~q; sm8 = ~sm;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency8", 64'(lat), 64'd9);
        e = sb8.pop_front();
        check("product8", 64'(p8), 64'(e));
        held = p8;
        for (int i = 0; i < hold; i++) begin
            iv8 = i[0]; m8 = 8'($urandom); q8 = 8'($urandom);
            @(posedge clk); #1;
            check("bp_valid8", 64'(ov8), 64'd1);
            check("bp_product8", 64'(p8), 64'(held));
            check("bp_ready8", 64'(ir8), 64'd0);
        end
        // With backpressure, in_valid stays high across the output handshake.
        iv8 = (hold > 0); or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0; iv8 = 1'b0;
        check("done_valid8", 64'(ov8), 64'd0);
        check("done_busy8", 64'(busy8), 64'd0);
        check("done_ready8", 64'(ir8), 64'd1);
    endtask

    task automatic op4(input logic [3:0] m, input logic [3:0] q, input logic sm,
                       input logic [7:0] exp);
        int lat;
        logic [7:0] e;
        @(negedge clk);
        check("accept_ready4", 64'(ir4), 64'd1);
        m4 = m; q4 = q; sm4 = sm; iv4 = 1'b1;
        @(posedge clk);
        sb4.push_back(exp);
        #1;
        iv4 = 1'b0; m4 = ~m; q4 = ~q; sm4 = ~sm;
        lat = 0;
        while (!ov4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency4", 64'(lat), 64'd5);
        e = sb4.pop_front();
        check("product4", 64'(p4), 64'(e));
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
        check("done_valid4", 64'(ov4), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        logic [7:0] rm, rq;
        logic       rs;
        rst_n = 1'b0;
        iv8 = 1'b0; m8 = '0; q8 = '0; sm8 = 1'b0; or8 = 1'b0;
        iv4 = 1'b0; m4 = '0; q4 = '0; sm4 = 1'b0; or4 = 1'b0;
        #23;
        check("rst_ready8", 64'(ir8), 64'd1);
        check("rst_valid8", 64'(ov8), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_product8", 64'(p8), 64'd0);
        check("rst_ready4", 64'(ir4), 64'd1);
        check("rst_valid4", 64'(ov4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed WIDTH=8 cases
        op8(8'd7,   8'hFD, 1'b1, 16'hFFEB, 0);   // 7 * -3
        op8(8'h80,  8'h80, 1'b1, 16'h4000, 0);   // -128 * -128
        op8(8'hFF,  8'hFF, 1'b0, 16'hFE01, 0);   // 255 * 255
        op8(8'h80,  8'h7F, 1'b1, 16'hC080, 0);   // -128 * 127
        op8(8'h80,  8'h80, 1'b0, 16'h4000, 0);   // 128 * 128 unsigned
        op8(8'd0,   8'hA5, 1'b1, 16'h0000, 0);
        // Backpressure with ignored in_valid pulses
        op8(8'd25,  8'hF6, 1'b1, 16'hFF06, 20);  // 25 * -10 = -250

        for (int i = 0; i < 12; i++) begin
            rm = 8'($urandom); rq = 8'($urandom); rs = 1'($urandom);
            op8(rm, rq, rs, ref_mul(rm, rq, rs, 8), 0);
        end

        // Reset during CALC, after three Booth steps have retired
        @(negedge clk);
        m8 = 8'd100; q8 = 8'd77; sm8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_busy8", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid8", 64'(ov8), 64'd0);
        check("midrst_ready8", 64'(ir8), 64'd1);
        check("midrst_busy8", 64'(busy8), 64'd0);
        check("midrst_product8", 64'(p8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (ov8) seen++;
        end
        check("no_stale_valid8", 64'(seen), 64'd0);
        op8(8'd3, 8'd5, 1'b1, 16'h000F, 0);

        // WIDTH=4 exhaustive, both modes
        op4(4'h8, 4'h7, 1'b1, 8'hC8);            // -8 * 7 = -56
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    rm = 8'(a); rq = 8'(b); rs = 1'(s);
                    op4(4'(a), 4'(b), rs, 8'(ref_mul(rm, rq, rs, 4)));
                end
            end
        end

        check("sb8_empty", 64'(sb8.size()), 64'd0);
        check("sb4_empty", 64'(sb4.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
